// File: rtl/cpu_run_control.sv
// cpu_run_control
//   Run-control stage behind the board support/reset sequencer. Synchronizes the
//   sequencer levels into the CPU clock domain and sequences CPU reset, boot,
//   run enable and interrupt request, with debug halt / single-step / resume and
//   a retired-cycle counter.
//
// Ports
//   cpu_clk          CPU clock, clocks every flop here
//   dcm_reset        asynchronous active-high reset
//   i_reset_in       sequencer reset level (async)
//   i_boot_in        sequencer boot level (async)
//   i_halt_in        sequencer halt level (async)
//   i_interrupt_in   interrupt level (async)
//   i_halt_req       debug halt pulse
//   i_run_req        debug resume pulse
//   i_step_req       debug single-step pulse
//   i_cycle_done     CPU retired one microinstruction this cycle
//   i_irq_ack        CPU accepted the interrupt
//   o_cpu_reset      CPU reset
//   o_cpu_boot       one-cycle boot strobe
//   o_cpu_run        CPU may advance
//   o_halted         CPU stopped in HALTED
//   o_step_ack       one-cycle pulse when a single step completes
//   o_irq            latched interrupt request
//   o_cycle_count    cycle_done pulses seen while o_cpu_run=1 (wraps)
module cpu_run_control #(
   parameter int RESET_STRETCH = 4,
   parameter int CNT_W         = 32
) (
   input  logic             cpu_clk,
   input  logic             dcm_reset,
   input  logic             i_reset_in,
   input  logic             i_boot_in,
   input  logic             i_halt_in,
   input  logic             i_interrupt_in,
   input  logic             i_halt_req,
   input  logic             i_run_req,
   input  logic             i_step_req,
   input  logic             i_cycle_done,
   input  logic             i_irq_ack,
   output logic             o_cpu_reset,
   output logic             o_cpu_boot,
   output logic             o_cpu_run,
   output logic             o_halted,
   output logic             o_step_ack,
   output logic             o_irq,
   output logic [CNT_W-1:0] o_cycle_count
);

   typedef enum logic [2:0] {
      S_RESET, S_WAIT_BOOT, S_RUN, S_HALTING, S_HALTED, S_STEP
   } state_t;

   localparam logic [3:0] STRETCH_MAX = 4'(RESET_STRETCH);

   // two-flop synchronizers; reset sync powers up asserted
   logic [1:0] r_rst_sync, r_boot_sync, r_halt_sync, r_int_sync;
   logic       r_boot_prev, r_int_prev;

   always_ff @(posedge cpu_clk or posedge dcm_reset) begin
      if (dcm_reset) begin
         r_rst_sync  <= 2'b11;
         r_boot_sync <= 2'b00;
         r_halt_sync <= 2'b00;
         r_int_sync  <= 2'b00;
         r_boot_prev <= 1'b0;
         r_int_prev  <= 1'b0;
      end else begin
         r_rst_sync  <= {r_rst_sync[0],  i_reset_in};
         r_boot_sync <= {r_boot_sync[0], i_boot_in};
         r_halt_sync <= {r_halt_sync[0], i_halt_in};
         r_int_sync  <= {r_int_sync[0],  i_interrupt_in};
         r_boot_prev <= r_boot_sync[1];
         r_int_prev  <= r_int_sync[1];
      end
   end

   logic w_rst_s, w_halt_s, w_boot_rise, w_int_rise;
   assign w_rst_s     = r_rst_sync[1];
   assign w_halt_s    = r_halt_sync[1];
   assign w_boot_rise = r_boot_sync[1] & ~r_boot_prev;
   assign w_int_rise  = r_int_sync[1]  & ~r_int_prev;

   state_t     r_state, w_next;
   logic [3:0] r_stretch, w_stretch_nxt;
   logic       w_boot_nxt, w_sack_nxt;

   always_ff @(posedge cpu_clk or posedge dcm_reset) begin
      if (dcm_reset) begin
         r_state   <= S_RESET;
         r_stretch <= 4'd0;
      end else begin
         r_state   <= w_next;
         r_stretch <= w_stretch_nxt;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_stretch_nxt = r_stretch;
      w_boot_nxt    = 1'b0;
      w_sack_nxt    = 1'b0;
      if (w_rst_s) begin
         // synchronized reset overrides everything and reloads the stretch
         w_next        = S_RESET;
         w_stretch_nxt = 4'd0;
      end else begin
         case (r_state)
            S_RESET: begin
               // r_stretch counts consecutive low cycles already seen
               if (r_stretch == STRETCH_MAX) w_next = S_WAIT_BOOT;
               else                          w_stretch_nxt = r_stretch + 4'd1;
            end
            S_WAIT_BOOT: begin
               if (w_boot_rise) begin
                  w_next     = S_RUN;
                  w_boot_nxt = 1'b1;
               end
            end
            S_RUN: begin
               if (i_halt_req || w_halt_s) w_next = S_HALTING;
            end
            S_HALTING: begin
               if (i_cycle_done) w_next = S_HALTED;
            end
            S_HALTED: begin
               if (i_step_req)                  w_next = S_STEP;
               else if (i_run_req && !w_halt_s) w_next = S_RUN;
            end
            S_STEP: begin
               if (i_cycle_done) begin
                  w_next     = S_HALTED;
                  w_sack_nxt = 1'b1;
               end
            end
            default: w_next = S_RESET;
         endcase
      end
   end

   // outputs registered from the next-state decode so they line up with r_state
   logic             r_cpu_reset, r_cpu_boot, r_cpu_run, r_halted, r_step_ack, r_irq;
   logic [CNT_W-1:0] r_count;
   logic             w_next_rst;
   assign w_next_rst = (w_next == S_RESET);

   always_ff @(posedge cpu_clk or posedge dcm_reset) begin
      if (dcm_reset) begin
         r_cpu_reset <= 1'b1;
         r_cpu_boot  <= 1'b0;
         r_cpu_run   <= 1'b0;
         r_halted    <= 1'b0;
         r_step_ack  <= 1'b0;
         r_irq       <= 1'b0;
         r_count     <= '0;
      end else begin
         r_cpu_reset <= w_next_rst;
         r_cpu_boot  <= w_boot_nxt;
         r_cpu_run   <= (w_next == S_RUN) || (w_next == S_HALTING) || (w_next == S_STEP);
         r_halted    <= (w_next == S_HALTED);
         r_step_ack  <= w_sack_nxt;
         if (w_next_rst)                    r_irq <= 1'b0;
         else if (w_int_rise)               r_irq <= 1'b1;   // set beats ack
         else if (i_irq_ack)                r_irq <= 1'b0;
         if (w_next_rst)                    r_count <= '0;
         else if (r_cpu_run && i_cycle_done) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_cpu_reset   = r_cpu_reset;
   assign o_cpu_boot    = r_cpu_boot;
   assign o_cpu_run     = r_cpu_run;
   assign o_halted      = r_halted;
   assign o_step_ack    = r_step_ack;
   assign o_irq         = r_irq;
   assign o_cycle_count = r_count;

endmodule

// File: tb/tb_cpu_run_control.sv
module tb_cpu_run_control;
   localparam int RS   = 4;
   localparam int CW   = 4;
   localparam int MODN = 1 << CW;

   logic cpu_clk = 1'b0;
   logic dcm_reset, reset_in, boot_in, halt_in, interrupt_in;
   logic halt_req, run_req, step_req, cycle_done, irq_ack;
   logic cpu_reset, cpu_boot, cpu_run, halted, step_ack, irq;
   logic [CW-1:0] cycle_count;

   always #5 cpu_clk = ~cpu_clk;

   cpu_run_control #(.RESET_STRETCH(RS), .CNT_W(CW)) dut (
      .cpu_clk(cpu_clk), .dcm_reset(dcm_reset),
      .i_reset_in(reset_in), .i_boot_in(boot_in), .i_halt_in(halt_in),
      .i_interrupt_in(interrupt_in), .i_halt_req(halt_req), .i_run_req(run_req),
      .i_step_req(step_req), .i_cycle_done(cycle_done), .i_irq_ack(irq_ack),
      .o_cpu_reset(cpu_reset), .o_cpu_boot(cpu_boot), .o_cpu_run(cpu_run),
      .o_halted(halted), .o_step_ack(step_ack), .o_irq(irq), .o_cycle_count(cycle_count)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int MD_RESET = 0, MD_WAIT = 1, MD_RUN = 2, MD_HALTING = 3, MD_HALTED = 4, MD_STEP = 5;
   int m_mode, nm, low_run, m_cnt;
   bit d1r, d2r, d1b, d2b, d1h, d2h, d1i, d2i, pb, pi;
   bit rs, bs, hs, is_, brise, irise;
   bit m_reset, m_boot, m_run, m_halted, m_sack, m_irq;

   always @(posedge cpu_clk or posedge dcm_reset) begin
      if (dcm_reset) begin
         d1r = 1; d2r = 1; d1b = 0; d2b = 0; d1h = 0; d2h = 0; d1i = 0; d2i = 0;
         pb = 0; pi = 0; low_run = 0; m_mode = MD_RESET; m_cnt = 0;
         m_reset = 1; m_boot = 0; m_run = 0; m_halted = 0; m_sack = 0; m_irq = 0;
      end else begin
         rs = d2r; bs = d2b; hs = d2h; is_ = d2i;
         brise = bs && !pb;
         irise = is_ && !pi;
         low_run = rs ? 0 : ((low_run < 1000) ? low_run + 1 : low_run);
         nm = m_mode;
         m_boot = 0;
         m_sack = 0;
         if (rs) nm = MD_RESET;
         else if (m_mode == MD_RESET) begin
            if (low_run > RS) nm = MD_WAIT;
         end else if (m_mode == MD_WAIT) begin
            if (brise) begin nm = MD_RUN; m_boot = 1; end
         end else if (m_mode == MD_RUN) begin
            if (halt_req || hs) nm = MD_HALTING;
         end else if (m_mode == MD_HALTING) begin
            if (cycle_done) nm = MD_HALTED;
         end else if (m_mode == MD_HALTED) begin
            if (step_req) nm = MD_STEP;
            else if (run_req && !hs) nm = MD_RUN;
         end else if (m_mode == MD_STEP) begin
            if (cycle_done) begin nm = MD_HALTED; m_sack = 1; end
         end
         if (m_run && cycle_done) m_cnt = (m_cnt + 1) % MODN;
         if (irise) m_irq = 1;
         else if (irq_ack) m_irq = 0;
         m_mode = nm;
         if (nm == MD_RESET) begin m_cnt = 0; m_irq = 0; end
         m_reset  = (nm == MD_RESET);
         m_run    = (nm == MD_RUN) || (nm == MD_HALTING) || (nm == MD_STEP);
         m_halted = (nm == MD_HALTED);
         pb = bs; pi = is_;
         d2r = d1r; d1r = reset_in;
         d2b = d1b; d1b = boot_in;
         d2h = d1h; d1h = halt_in;
         d2i = d1i; d1i = interrupt_in;
      end
   end

   always @(negedge cpu_clk) begin
      if (chk_en) begin
         check("m_cpu_reset", 32'(cpu_reset), 32'(m_reset));
         check("m_cpu_boot",  32'(cpu_boot),  32'(m_boot));
         check("m_cpu_run",   32'(cpu_run),   32'(m_run));
         check("m_halted",    32'(halted),    32'(m_halted));
         check("m_step_ack",  32'(step_ack),  32'(m_sack));
         check("m_irq",       32'(irq),       32'(m_irq));
         check("m_count",     32'(cycle_count), 32'(m_cnt));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge cpu_clk);
      #2;
   endtask

   int boot_pulses, boot_at;

   initial begin
      dcm_reset = 1; reset_in = 1; boot_in = 0; halt_in = 0; interrupt_in = 0;
      halt_req = 0; run_req = 0; step_req = 0; cycle_done = 0; irq_ack = 0;
      repeat (3) tick();
      chk_en = 1;
      check("rst_cpu_reset", 32'(cpu_reset), 1);
      check("rst_cpu_run", 32'(cpu_run), 0);
      check("rst_count", 32'(cycle_count), 0);
      check("rst_irq", 32'(irq), 0);

      // power-up: cpu_reset falls 2+RS+1 = 7 cycles after reset_in drops
      dcm_reset = 0; reset_in = 0;
      repeat (6) tick();
      check("pwr_reset_hold", 32'(cpu_reset), 1);
      tick();
      check("pwr_reset_fall", 32'(cpu_reset), 0);

      // boot held 8 cycles: single strobe, 3 cycles after the rise
      boot_in = 1; boot_pulses = 0; boot_at = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (cpu_boot) begin boot_pulses++; boot_at = i; end
      end
      boot_in = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cpu_boot) boot_pulses++;
      end
      check("boot_pulses", 32'(boot_pulses), 1);
      check("boot_latency", 32'(boot_at), 3);
      check("boot_run", 32'(cpu_run), 1);

      // debug halt with cycle_done 3 cycles after the pulse
      halt_req = 1; tick(); halt_req = 0;
      check("halting_run", 32'(cpu_run), 1);
      tick(); tick();
      cycle_done = 1; tick(); cycle_done = 0;
      check("halt_halted", 32'(halted), 1);
      check("halt_run", 32'(cpu_run), 0);
      check("halt_count", 32'(cycle_count), 1);

      // single step
      step_req = 1; tick(); step_req = 0;
      check("step_run", 32'(cpu_run), 1);
      tick();
      cycle_done = 1; tick(); cycle_done = 0;
      check("step_ack", 32'(step_ack), 1);
      check("step_halted", 32'(halted), 1);
      check("step_count", 32'(cycle_count), 2);
      tick();
      check("step_ack_drop", 32'(step_ack), 0);

      // resume
      run_req = 1; tick(); run_req = 0;
      check("resume_run", 32'(cpu_run), 1);
      check("resume_halted", 32'(halted), 0);

      // sequencer halt level: run_req ignored while it is high
      halt_in = 1; repeat (3) tick();
      check("hin_halting", 32'(cpu_run), 1);
      cycle_done = 1; tick(); cycle_done = 0;
      check("hin_halted", 32'(halted), 1);
      check("hin_count", 32'(cycle_count), 3);
      run_req = 1; tick(); run_req = 0; tick();
      check("hin_run_ignored", 32'(halted), 1);
      halt_in = 0; repeat (3) tick();
      run_req = 1; tick(); run_req = 0;
      check("hin_resume", 32'(cpu_run), 1);

      // interrupt: ack coincident with set leaves irq high
      interrupt_in = 1; tick(); tick();
      irq_ack = 1; tick(); irq_ack = 0;
      check("irq_set_wins", 32'(irq), 1);
      tick();
      irq_ack = 1; tick(); irq_ack = 0;
      check("irq_cleared", 32'(irq), 0);
      interrupt_in = 0; repeat (3) tick();
      interrupt_in = 1; repeat (3) tick();
      check("irq_reset_again", 32'(irq), 1);

      // reset mid-step, cycle_done on the cycle reset wins
      halt_req = 1; tick(); halt_req = 0;
      cycle_done = 1; tick(); cycle_done = 0;
      check("pre_step_count", 32'(cycle_count), 4);
      step_req = 1; tick(); step_req = 0;
      reset_in = 1; tick(); tick();
      cycle_done = 1; tick(); cycle_done = 0;
      check("mid_rst_reset", 32'(cpu_reset), 1);
      check("mid_rst_run", 32'(cpu_run), 0);
      check("mid_rst_irq", 32'(irq), 0);
      check("mid_rst_count", 32'(cycle_count), 0);
      check("mid_rst_no_ack", 32'(step_ack), 0);
      interrupt_in = 0;

      // recover, boot, and wrap the 4-bit counter with 17 pulses
      reset_in = 0; repeat (7) tick();
      check("rec_reset_fall", 32'(cpu_reset), 0);
      boot_in = 1; repeat (4) tick(); boot_in = 0;
      check("rec_run", 32'(cpu_run), 1);
      cycle_done = 1;
      repeat (15) tick();
      check("wrap_15", 32'(cycle_count), 15);
      tick();
      check("wrap_0", 32'(cycle_count), 0);
      tick();
      cycle_done = 0;
      check("wrap_1", 32'(cycle_count), 1);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_run_control.md
# cpu_run_control

Run-control stage directly downstream of the board support/reset sequencer. Takes the sequencer's `reset`, `boot`, `halt` and `interrupt` levels, synchronizes them into the CPU clock domain, and produces the CPU's reset, boot strobe, run enable and interrupt request. It also adds debug halt, single-step and resume control, plus a retired-cycle counter.

## Interface
Parameters:
- RESET_STRETCH, 4: cycles `cpu_reset` stays high after synchronized reset deasserts (1..15).
- CNT_W, 32: width of `cycle_count`.

Ports:
- cpu_clk  in  1  CPU clock; every flop in this block is clocked by it.
- dcm_reset  in  1  asynchronous, active-high reset.
- reset_in  in  1  reset level from the support sequencer (asynchronous to cpu_clk).
- boot_in  in  1  boot level from the support sequencer (asynchronous).
- halt_in  in  1  halt level from the support sequencer (asynchronous).
- interrupt_in  in  1  interrupt level (asynchronous).
- halt_req  in  1  debug halt request, synchronous single-cycle pulse.
- run_req  in  1  debug resume, synchronous pulse.
- step_req  in  1  debug single step, synchronous pulse.
- cycle_done  in  1  CPU retired one microinstruction this cycle.
- irq_ack  in  1  CPU accepted the interrupt, synchronous pulse.
- cpu_reset  out  1  CPU reset.
- cpu_boot  out  1  one-cycle boot strobe.
- cpu_run  out  1  CPU may advance.
- halted  out  1  CPU is stopped in HALTED.
- step_ack  out  1  one-cycle pulse when a single step completes.
- irq  out  1  latched interrupt request.
- cycle_count  out  CNT_W  number of `cycle_done` pulses seen while `cpu_run`=1.

## Operation
- Synchronizers: `reset_in`, `boot_in`, `halt_in` and `interrupt_in` each pass through a two-flop synchronizer. Synchronizer flops reset to 0, except the `reset_in` synchronizer, which resets to 1. Edge detectors act on the synchronized value against its previous-cycle copy.
- State machine states: RESET, WAIT_BOOT, RUN, HALTING, HALTED, STEP.
  - RESET: `cpu_reset`=1. Once synchronized reset has been low for RESET_STRETCH consecutive cycles, go to WAIT_BOOT.
  - WAIT_BOOT: on a rising edge of synchronized boot, pulse `cpu_boot` and go to RUN.
  - RUN: `cpu_run`=1. If `halt_req` is seen, or synchronized halt is 1, go to HALTING.
  - HALTING: `cpu_run`=1 until `cycle_done`, then go to HALTED. If `cycle_done` is present on the cycle of entry, HALTED is reached on the next cycle.
  - HALTED: `halted`=1 and `cpu_run`=0. `step_req` moves to STEP. `run_req` moves to RUN only while synchronized halt is 0; otherwise it is ignored. If both arrive together, step wins.
  - STEP: `cpu_run`=1 until `cycle_done`, then pulse `step_ack` and return to HALTED.
- Synchronized reset = 1 in any state forces RESET on the next edge and reloads the stretch counter. This has priority over every other transition.
- Interrupt:
  - A rising edge of synchronized interrupt sets `irq`; `irq_ack` clears it.
  - Set and ack on the same cycle leave `irq`=1.
  - `irq` is cleared in RESET.
- `cycle_count`:
  - Increments when `cpu_run`=1 and `cycle_done`=1.
  - Wraps from all-ones to 0.
  - Cleared while in RESET.
- `cycle_done`, `halt_req`, `run_req` and `step_req` are ignored in states where they are not listed.

## Timing
- Reset values on `dcm_reset`: state RESET, `cpu_reset`=1, `cpu_boot`=0, `cpu_run`=0, `halted`=0, `step_ack`=0, `irq`=0, `cycle_count`=0.
- All outputs are registered (Moore outputs from the state/output flops).
- Synchronizer latency: an input change becomes visible at the state machine 2 cycles later. An edge on it affects the outputs 3 cycles after the input changes.
- `cpu_reset` deassert: RESET_STRETCH+1 cycles after synchronized reset falls.
- `cpu_boot`: exactly one cycle wide. Only one strobe is issued per boot level, however long `boot_in` stays high.
- Halt latency from `halt_req` (in RUN): `cpu_run` stays 1 through the first `cycle_done`. `halted` rises the cycle after that `cycle_done`.
- `step_ack` and the return to `halted`=1 appear on the same edge, the one after `cycle_done` in STEP.
- A debug request (`halt_req`, `run_req`, `step_req`) takes effect on the edge following its pulse.

## Test plan
- Power-up: hold `dcm_reset` with `reset_in`=1, then release and drop `reset_in`. Required: `cpu_reset` falls 2+RESET_STRETCH+1 = 7 cycles later. Then raise `boot_in` for 8 cycles. Required: exactly one `cpu_boot` pulse, then `cpu_run`=1.
- Halt/step/resume: from RUN, pulse `halt_req` and give `cycle_done` 3 cycles later. Required: `halted`=1 on the following cycle. Next, pulse `step_req` with `cycle_done` 2 cycles later. Required: one `step_ack` pulse, `cycle_count` up by 1. Finally, pulse `run_req`. Required: RUN.
- `halt_in`=1 while in RUN: goes to HALTED, and `run_req` is ignored until `halt_in` drops.
- Interrupt: raise `interrupt_in`, then assert `irq_ack` on the same cycle `irq` would set. Required: `irq` stays 1. A later `irq_ack` alone clears it.
- Reset mid-operation: raise `reset_in` during STEP. Required: RESET, `cpu_run`=0, `irq`=0, `cycle_count`=0, and no `step_ack`.
- Counter wrap: use CNT_W=4 and give 17 `cycle_done` pulses while running. Required: `cycle_count`=1.
